word_accum: RTL and testbench



---
 rtl/word_accum_if.sv | 27 ++
 rtl/word_accum.sv | 90 +++++++++
 tb/tb_word_accum.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/word_accum_if.sv
// Handshake bundle between the word accumulator, its upstream latch stage and the result consumer.
interface word_accum_if #(
    parameter int unsigned NUM_WORDS = 4,
    parameter int unsigned SUM_W     = 32
);
    localparam int unsigned CNT_W = $clog2(NUM_WORDS + 1);

    logic             in_vld;
    logic [31:0]      in_data;
    logic             in_ack;
    logic             flush;
    logic             res_vld;
    logic [SUM_W-1:0] res_sum;
    logic [CNT_W-1:0] res_cnt;
    logic             res_ack;
    logic             busy;

    modport master (
        output in_vld, in_data, flush, res_ack,
        input  in_ack, res_vld, res_sum, res_cnt, busy
    );

    modport slave (
        input  in_vld, in_data, flush, res_ack,
        output in_ack, res_vld, res_sum, res_cnt, busy
    );
endinterface

// File: rtl/word_accum.sv
// Sums groups of NUM_WORDS upstream words (or fewer on flush) and holds the result until acknowledged.
// Optional build macro WORD_ACCUM_SAT_EN: saturating adds instead of modulo wrap.
module word_accum #(
    parameter int unsigned NUM_WORDS = 4,
    parameter int unsigned SUM_W     = 32
) (
    input  logic          ap_clk,
    input  logic          ap_rst,
    word_accum_if.slave   bus
);
    localparam int unsigned CNT_W = $clog2(NUM_WORDS + 1);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t           state_q, state_d;
    logic [SUM_W-1:0] sum_q, sum_d, word, sum_add;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             res_vld_q, busy_q;
    logic             ack_c, accept;

    // Combinational ack so the latch stage sees it in the cycle it presents the word
    assign ack_c  = bus.in_vld && (state_q != DONE) && !ap_rst;
    assign accept = bus.in_vld && ack_c;
    assign word   = SUM_W'(bus.in_data);

`ifdef WORD_ACCUM_SAT_EN
    logic [SUM_W:0] total;
    always_comb begin
        total   = {1'b0, sum_q} + {1'b0, word};
        sum_add = total[SUM_W] ? '1 : total[SUM_W-1:0];
    end
`else
    always_comb begin
        sum_add = sum_q + word;
    end
`endif

    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, ACCUM: begin
                if (accept) begin
                    sum_d = sum_add;
                    cnt_d = cnt_q + CNT_W'(1);
                    if ((cnt_d == CNT_W'(NUM_WORDS)) || bus.flush) begin
                        state_d = DONE;
                    end else begin
                        state_d = ACCUM;
                    end
                end else if (bus.flush && (state_q == ACCUM)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.res_ack) begin
                    state_d = IDLE;
                    sum_d   = '0;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q   <= IDLE;
            sum_q     <= '0;
            cnt_q     <= '0;
            res_vld_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sum_q     <= sum_d;
            cnt_q     <= cnt_d;
            res_vld_q <= (state_d == DONE);
            busy_q    <= (state_d != IDLE);
        end
    end

    assign bus.in_ack  = ack_c;
    assign bus.res_vld = res_vld_q;
    assign bus.res_sum = sum_q;
    assign bus.res_cnt = cnt_q;
    assign bus.busy    = busy_q;
endmodule

// File: tb/tb_word_accum.sv
// Self-checking bench for word_accum: directed plan steps followed by randomized traffic vs a group-level model.
module tb_word_accum;
    localparam int unsigned NW   = 4;
    localparam int unsigned SW   = 32;
    localparam longint unsigned MASK = 64'h0000_0000_FFFF_FFFF;

    logic clk;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_ack = 0;

    // Reference model: words collected in the open group, and whether a result is pending
    longint unsigned m_sum;
    int              m_cnt;
    bit              m_pend;
    bit              m_acc;

    word_accum_if #(.NUM_WORDS(NW), .SUM_W(SW)) bus ();

    word_accum #(.NUM_WORDS(NW), .SUM_W(SW)) dut (
        .ap_clk (clk),
        .ap_rst (rst),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic longint unsigned add_word(input longint unsigned s, input logic [31:0] d);
        longint unsigned t;
        t = s + longint'(d);
`ifdef WORD_ACCUM_SAT_EN
        return (t > MASK) ? MASK : t;
`else
        return t & MASK;
`endif
    endfunction

    // One clock: drive, check outputs against the model, then advance the model across the edge
    task automatic cycle(input bit v, input logic [31:0] d, input bit fl, input bit ak);
        bit exp_ack;
        bus.in_vld  = v;
        bus.in_data = d;
        bus.flush   = fl;
        bus.res_ack = ak;
        #1;
        exp_ack = v && !m_pend;
        check("in_ack", 64'(bus.in_ack), 64'(exp_ack));
        check("res_vld", 64'(bus.res_vld), 64'(m_pend));
        check("busy", 64'(bus.busy), 64'(m_pend || (m_cnt != 0)));
        if (m_pend) begin
            check("res_sum", 64'(bus.res_sum), m_sum);
            check("res_cnt", 64'(bus.res_cnt), 64'(m_cnt));
        end
        if (bus.in_ack === 1'b1) n_ack++;
        m_acc = exp_ack;
        if (m_pend) begin
            if (ak) begin
                m_pend = 1'b0;
                m_sum  = 0;
                m_cnt  = 0;
            end
        end else if (exp_ack) begin
            m_sum = add_word(m_sum, d);
            m_cnt++;
            if ((m_cnt == int'(NW)) || fl) m_pend = 1'b1;
        end else if (fl && (m_cnt != 0)) begin
            m_pend = 1'b1;
        end
        @(negedge clk);
    endtask

    // Present a word until taken, then idle one cycle while the latch reloads
    task automatic send(input logic [31:0] d, input bit fl, input bit ak);
        int tries = 0;
        do begin
            cycle(1'b1, d, fl, ak);
            tries++;
        end while (!m_acc && tries < 16);
        check("send_accepted", 64'(m_acc), 64'(1));
        cycle(1'b0, 32'h0, 1'b0, ak);
    endtask

    task automatic expect_result(input string tag, input logic [31:0] s, input int c);
        #1;
        check({tag, "_vld"}, 64'(bus.res_vld), 64'(1));
        check({tag, "_sum"}, 64'(bus.res_sum), 64'(s));
        check({tag, "_cnt"}, 64'(bus.res_cnt), 64'(c));
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        bus.in_vld  = 1'b1;
        bus.in_data = 32'hDEAD_BEEF;
        bus.flush   = 1'b0;
        bus.res_ack = 1'b0;
        #1;
        check("rst_in_ack", 64'(bus.in_ack), 64'(0));
        @(negedge clk);
        check("rst_res_vld", 64'(bus.res_vld), 64'(0));
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_res_sum", 64'(bus.res_sum), 64'(0));
        check("rst_res_cnt", 64'(bus.res_cnt), 64'(0));
        check("rst_in_ack_held", 64'(bus.in_ack), 64'(0));
        rst        = 1'b0;
        bus.in_vld = 1'b0;
        m_sum  = 0;
        m_cnt  = 0;
        m_pend = 1'b0;
        m_acc  = 1'b0;
    endtask

    initial begin
        bit              have;
        logic [31:0]     w;
        do_reset();

        // Basic group with res_ack held high
        n_ack = 0;
        send(32'd1, 1'b0, 1'b1);
        send(32'd2, 1'b0, 1'b1);
        send(32'd3, 1'b0, 1'b1);
        send(32'd4, 1'b0, 1'b0);
        expect_result("basic", 32'd10, 4);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        check("basic_ack_pulses", 64'(n_ack), 64'(4));

        // Backpressure: result pending while upstream presents 0x7
        send(32'd5, 1'b0, 1'b1);
        send(32'd5, 1'b0, 1'b1);
        send(32'd5, 1'b0, 1'b1);
        send(32'd5, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b1, 32'h7, 1'b0, 1'b0);
        expect_result("bp", 32'd20, 4);
        cycle(1'b1, 32'h7, 1'b0, 1'b1);
        cycle(1'b1, 32'h7, 1'b0, 1'b0);
        check("bp_next_accept", 64'(m_acc), 64'(1));
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        expect_result("bp_new_group", 32'h7, 1);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);

        // Early flush, then flush on the same edge as an accept
        send(32'h10, 1'b0, 1'b0);
        send(32'h20, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        expect_result("flush", 32'h30, 2);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        send(32'h10, 1'b0, 1'b0);
        send(32'h20, 1'b0, 1'b0);
        send(32'h40, 1'b1, 1'b0);
        expect_result("flush_accept", 32'h70, 3);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);

        // Flush in IDLE produces nothing
        cycle(1'b0, 32'h0, 1'b1, 1'b1);
        cycle(1'b0, 32'h0, 1'b1, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) send(32'd1, 1'b0, 1'b1);
        send(32'd1, 1'b0, 1'b0);
        expect_result("after_idle_flush", 32'd4, 4);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);

        // Overflow at the accumulator width
        send(32'hFFFF_FFFF, 1'b0, 1'b0);
        send(32'h2, 1'b1, 1'b0);
`ifdef WORD_ACCUM_SAT_EN
        expect_result("overflow", 32'hFFFF_FFFF, 2);
`else
        expect_result("overflow", 32'h0000_0001, 2);
`endif
        cycle(1'b0, 32'h0, 1'b0, 1'b1);

        // Reset mid-group discards the partial sum
        send(32'd9, 1'b0, 1'b1);
        send(32'd9, 1'b0, 1'b1);
        do_reset();
        for (int i = 0; i < 3; i++) send(32'd1, 1'b0, 1'b1);
        send(32'd1, 1'b0, 1'b0);
        expect_result("after_reset", 32'd4, 4);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);

        // Randomized traffic: upstream holds a word until taken, random flush and res_ack
        have = 1'b0;
        w    = 32'h0;
        for (int i = 0; i < 600; i++) begin
            if (!have && ($urandom_range(0, 2) != 0)) begin
                have = 1'b1;
                w    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FF00 | 32'($urandom_range(0, 255)))
                                                  : $urandom;
            end
            cycle(have, w, ($urandom_range(0, 7) == 0), ($urandom_range(0, 1) == 1));
            if (m_acc) have = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
